// File: rtl/vx_perf_memsys_ctr.sv
// Memory-system performance counter bank: event/latency counters,
// shadow snapshot, sticky overflow, outstanding-request tracking.
module vx_perf_memsys_ctr #(
  parameter int NUM_EVENTS = 14,
  parameter int CTR_BITS   = 44,
  parameter int INC_BITS   = 4,
  parameter int PEND_BITS  = 8,
  parameter bit SATURATE   = 1'b0,
  parameter int SEL_BITS   = $clog2(NUM_EVENTS+1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           snapshot,
  input  logic [NUM_EVENTS*INC_BITS-1:0] evt_inc,
  input  logic                           mem_req_fire,
  input  logic                           mem_rsp_fire,
  input  logic [SEL_BITS-1:0]            rd_sel,
  output logic [CTR_BITS-1:0]            rd_data,
  output logic [NUM_EVENTS:0]            ovf,
  output logic [PEND_BITS-1:0]           pending,
  output logic                           pend_err
);

  localparam int NC = NUM_EVENTS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
  localparam logic [SEL_BITS-1:0] LAT_SEL = SEL_BITS'(NUM_EVENTS);

  logic [CTR_BITS-1:0] live     [NC];
  logic [CTR_BITS-1:0] shadow   [NC];
  logic [CTR_BITS-1:0] live_nxt [NC];
  logic [NUM_EVENTS:0] carry;

  logic req_only;
  logic rsp_only;

  assign req_only = mem_req_fire & ~mem_rsp_fire;
  assign rsp_only = mem_rsp_fire & ~mem_req_fire;

  // Latency slot uses the pending count registered at cycle start.
  for (genvar k = 0; k < NC; k++) begin : g_ctr
    logic [CTR_BITS-1:0] inc;
    logic [CTR_BITS:0]   sum;
    if (k < NUM_EVENTS) begin : g_evt
      assign inc = CTR_BITS'(evt_inc[k*INC_BITS +: INC_BITS]);
    end else begin : g_lat
      assign inc = CTR_BITS'(pending);
    end
    assign sum = {1'b0, live[k]} + {1'b0, inc};
    assign carry[k] = sum[CTR_BITS];
    assign live_nxt[k] =
      (SATURATE && carry[k]) ? CTR_MAX : sum[CTR_BITS-1:0];
  end

  // Live bank and sticky overflow; clear beats accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NC; k++) live[k] <= '0;
      ovf <= '0;
    end else if (clear) begin
      for (int k = 0; k < NC; k++) live[k] <= '0;
      ovf <= '0;
    end else if (enable) begin
      for (int k = 0; k < NC; k++) live[k] <= live_nxt[k];
      ovf <= ovf | carry;
    end
  end

  // Shadow bank captures the pre-edge live values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NC; k++) shadow[k] <= '0;
    end else if (snapshot) begin
      for (int k = 0; k < NC; k++) shadow[k] <= live[k];
    end
  end

  // Registered read of the shadow bank; out-of-range selects read 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_sel <= LAT_SEL) begin
      rd_data <= shadow[rd_sel];
    end else begin
      rd_data <= '0;
    end
  end

  // Outstanding requests; ignores enable and clear, holds at limits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      pend_err <= 1'b0;
    end else begin
      unique case (1'b1)
        req_only: begin
          if (pending == PEND_MAX) pend_err <= 1'b1;
          else pending <= pending + PEND_BITS'(1);
        end
        rsp_only: begin
          if (pending == '0) pend_err <= 1'b1;
          else pending <= pending - PEND_BITS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_perf_memsys_ctr.sv
// Bench for vx_perf_memsys_ctr: directed corner sequences, a vector
// table for pending edges and randomized runs against a reference model.
module tb_vx_perf_memsys_ctr;

  localparam int NE = 14;
  localparam int NC = 15;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic          snapshot;
  logic [NE*4-1:0] evt_inc;
  logic          mem_req_fire;
  logic          mem_rsp_fire;
  logic [SB-1:0] rd_sel;

  logic [43:0] rd_data;
  logic [7:0]  rd_data_w, rd_data_s;
  logic [14:0] ovf, ovf_w, ovf_s;
  logic [7:0]  pending, pending_w, pending_s;
  logic        pend_err, pend_err_w, pend_err_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vx_perf_memsys_ctr dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .snapshot(snapshot), .evt_inc(evt_inc),
    .mem_req_fire(mem_req_fire), .mem_rsp_fire(mem_rsp_fire),
    .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf),
    .pending(pending), .pend_err(pend_err)
  );

  vx_perf_memsys_ctr #(.CTR_BITS(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .snapshot(snapshot), .evt_inc(evt_inc),
    .mem_req_fire(mem_req_fire), .mem_rsp_fire(mem_rsp_fire),
    .rd_sel(rd_sel), .rd_data(rd_data_w), .ovf(ovf_w),
    .pending(pending_w), .pend_err(pend_err_w)
  );

  vx_perf_memsys_ctr #(.CTR_BITS(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .snapshot(snapshot), .evt_inc(evt_inc),
    .mem_req_fire(mem_req_fire), .mem_rsp_fire(mem_rsp_fire),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .ovf(ovf_s),
    .pending(pending_s), .pend_err(pend_err_s)
  );

  // Reference model: index 0 = 44-bit wrap, 1 = 8-bit wrap, 2 = 8-bit sat
  int              cfg_w   [3] = '{44, 8, 8};
  bit              cfg_sat [3] = '{1'b0, 1'b0, 1'b1};
  longint unsigned m_live  [3][NC];
  longint unsigned m_shad  [3][NC];
  longint unsigned m_rd    [3];
  logic [14:0]     m_ovf   [3];
  int unsigned     m_pend;
  bit              m_err;

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NC; k++) begin
        m_live[c][k] = 0;
        m_shad[c][k] = 0;
      end
      m_rd[c]  = 0;
      m_ovf[c] = '0;
    end
    m_pend = 0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step();
    longint unsigned maxv, inc, s;
    for (int c = 0; c < 3; c++) begin
      maxv = (64'd1 << cfg_w[c]) - 64'd1;
      m_rd[c] = (int'(rd_sel) < NC) ? m_shad[c][rd_sel] : 0;
      if (snapshot)
        for (int k = 0; k < NC; k++) m_shad[c][k] = m_live[c][k];
      if (clear) begin
        for (int k = 0; k < NC; k++) m_live[c][k] = 0;
        m_ovf[c] = '0;
      end else if (enable) begin
        for (int k = 0; k < NC; k++) begin
          inc = (k < NE) ? 64'(evt_inc[k*4 +: 4]) : 64'(m_pend);
          s = m_live[c][k] + inc;
          if (s > maxv) begin
            m_ovf[c][k] = 1'b1;
            m_live[c][k] = cfg_sat[c] ? maxv : s - (maxv + 64'd1);
          end else begin
            m_live[c][k] = s;
          end
        end
      end
    end
    if (mem_req_fire && !mem_rsp_fire) begin
      if (m_pend == 255) m_err = 1'b1;
      else m_pend++;
    end else if (mem_rsp_fire && !mem_req_fire) begin
      if (m_pend == 0) m_err = 1'b1;
      else m_pend--;
    end
  endfunction

  task automatic check(input string name,
                       input longint unsigned act,
                       input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all();
    check("pending",    64'(pending),    64'(m_pend));
    check("pend_err",   64'(pend_err),   64'(m_err));
    check("ovf",        64'(ovf),        64'(m_ovf[0]));
    check("rd_data",    64'(rd_data),    m_rd[0]);
    check("pending_w",  64'(pending_w),  64'(m_pend));
    check("ovf_w",      64'(ovf_w),      64'(m_ovf[1]));
    check("rd_data_w",  64'(rd_data_w),  m_rd[1]);
    check("pend_err_s", 64'(pend_err_s), 64'(m_err));
    check("ovf_s",      64'(ovf_s),      64'(m_ovf[2]));
    check("rd_data_s",  64'(rd_data_s),  m_rd[2]);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    enable       = 1'b0;
    clear        = 1'b0;
    snapshot     = 1'b0;
    evt_inc      = '0;
    mem_req_fire = 1'b0;
    mem_rsp_fire = 1'b0;
    rd_sel       = '0;
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    evt_inc      = r[NE*4-1:0];
    enable       = ($urandom_range(0, 3) != 0);
    clear        = ($urandom_range(0, 15) == 0);
    snapshot     = ($urandom_range(0, 5) == 0);
    mem_req_fire = 1'(($urandom() >> 3) & 1);
    mem_rsp_fire = 1'(($urandom() >> 5) & 1);
    rd_sel       = SB'($urandom_range(0, 15));
  endtask

  typedef struct {
    bit         req;
    bit         rsp;
    logic [3:0] sel;
    int         exp_pend;
    bit         exp_err;
    bit         chk_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'd0,  0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'd0,  1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'd0,  2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'd0,  3, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'd0,  4, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd0,  5, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'd0,  5, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 4'd15, 4, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 4'd15, 4, 1'b1, 1'b1};

    // power-on reset
    reset_n = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // T1: random run, then asynchronous reset mid-cycle
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      step();
    end
    rand_inputs();
    #3 reset_n = 1'b0;
    #1;
    check("rst_rd_data",  64'(rd_data),  0);
    check("rst_ovf",      64'(ovf),      0);
    check("rst_pending",  64'(pending),  0);
    check("rst_pend_err", 64'(pend_err), 0);
    check("rst_rd_w",     64'(rd_data_w), 0);
    check("rst_ovf_s",    64'(ovf_s),    0);
    model_reset();
    step();
    idle();
    reset_n = 1'b1;
    for (int s = 0; s < NC; s++) begin
      rd_sel = SB'(s);
      step();
      check("rst_read", 64'(rd_data), 0);
    end
    rd_sel = '0;
    step();

    // T2: accumulate on ch0 and ch13
    idle();
    clear = 1'b1;
    step();
    idle();
    enable = 1'b1;
    evt_inc[0 +: 4] = 4'd3;
    repeat (10) step();
    evt_inc = '0;
    evt_inc[13*4 +: 4] = 4'd15;
    repeat (2) step();
    idle();
    snapshot = 1'b1;
    step();
    idle();
    rd_sel = 4'd0;
    step();
    check("t2_ch0", 64'(rd_data), 30);
    rd_sel = 4'd13;
    step();
    check("t2_ch13", 64'(rd_data), 30);

    // T3: 8-bit wrap and saturate on ch1
    idle();
    clear = 1'b1;
    step();
    idle();
    enable = 1'b1;
    evt_inc[1*4 +: 4] = 4'd15;
    repeat (18) step();
    idle();
    snapshot = 1'b1;
    step();
    idle();
    rd_sel = 4'd1;
    step();
    check("t3_wrap",     64'(rd_data_w), 14);
    check("t3_sat",      64'(rd_data_s), 255);
    check("t3_wide",     64'(rd_data),   270);
    check("t3_ovf_wrap", 64'(ovf_w[1]),  1);
    check("t3_ovf_sat",  64'(ovf_s[1]),  1);
    check("t3_ovf_wide", 64'(ovf[1]),    0);

    // T4: latency accumulation from outstanding requests
    idle();
    clear = 1'b1;
    step();
    idle();
    enable = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      mem_req_fire = (cyc < 3);
      mem_rsp_fire = (cyc >= 5);
      step();
    end
    idle();
    snapshot = 1'b1;
    step();
    idle();
    rd_sel = 4'd14;
    step();
    check("t4_latency", 64'(rd_data), 15);
    check("t4_pending", 64'(pending), 0);

    // T5: snapshot and clear together
    idle();
    clear = 1'b1;
    step();
    idle();
    enable = 1'b1;
    evt_inc[0 +: 4] = 4'd10;
    for (int cyc = 0; cyc < 10; cyc++) begin
      mem_req_fire = (cyc < 2);
      step();
    end
    idle();
    snapshot = 1'b1;
    clear    = 1'b1;
    step();
    check("t5_pending", 64'(pending), 2);
    idle();
    rd_sel = 4'd0;
    step();
    check("t5_old", 64'(rd_data), 100);
    snapshot = 1'b1;
    step();
    idle();
    step();
    check("t5_new", 64'(rd_data), 0);
    mem_rsp_fire = 1'b1;
    repeat (2) step();
    idle();
    step();
    check("t5_drain", 64'(pending), 0);

    // T6: pending edges from the vector table
    for (int i = 0; i < 9; i++) begin
      idle();
      mem_req_fire = tbl[i].req;
      mem_rsp_fire = tbl[i].rsp;
      rd_sel       = tbl[i].sel;
      step();
      check($sformatf("t6_pend[%0d]", i), 64'(pending),
            64'(tbl[i].exp_pend));
      check($sformatf("t6_err[%0d]", i), 64'(pend_err),
            64'(tbl[i].exp_err));
      if (tbl[i].chk_rd)
        check($sformatf("t6_rd[%0d]", i), 64'(rd_data), 0);
    end

    // random run against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
